// File: rtl/rtc_bus_arbiter_pkg.sv
// Shared types and constants for the RTC bus arbiter.
// FSM encoding, RTC register map and driver direction codes.
package rtc_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANTED,
    ST_START,
    ST_BUSY
  } arb_state_e;

  localparam logic [7:0] RTC_SEC     = 8'h21;
  localparam logic [7:0] RTC_MIN     = 8'h22;
  localparam logic [7:0] RTC_HOUR    = 8'h23;
  localparam logic [7:0] RTC_DAY     = 8'h24;
  localparam logic [7:0] RTC_MONTH   = 8'h25;
  localparam logic [7:0] RTC_YEAR    = 8'h26;
  localparam logic [7:0] RTC_WDAY    = 8'h27;
  localparam logic [7:0] RTC_RD_XFER = 8'hF0;
  localparam logic [7:0] RTC_WR_XFER = 8'hF1;

  localparam logic LEA     = 1'b0;
  localparam logic ESCRIBA = 1'b1;

endpackage

// File: rtl/rtc_bus_arbiter_if.sv
// Requester-side and driver-side signals of the RTC bus arbiter.
// master = requesters + driver, slave = arbiter.
interface rtc_bus_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   stb;
  logic [N_REQ-1:0]   we;
  logic [8*N_REQ-1:0] addr;
  logic [8*N_REQ-1:0] wdata;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic               err;
  logic [7:0]         rdata;
  logic [7:0]         direc;
  logic [7:0]         dato;
  logic               lea_escriba;
  logic               flag_rtc;
  logic               siga;
  logic [7:0]         rtc_rdata;

  modport master (
    output req, stb, we, addr, wdata,
    output siga, rtc_rdata,
    input  gnt, done, err, rdata,
    input  direc, dato, lea_escriba, flag_rtc
  );

  modport slave (
    input  req, stb, we, addr, wdata,
    input  siga, rtc_rdata,
    output gnt, done, err, rdata,
    output direc, dato, lea_escriba, flag_rtc
  );

endinterface

// File: rtl/rtc_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or
// after the pointer, wrapping; returns one-hot, index and valid.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [PW-1:0]    idx_o,
  output logic             valid_o
);

  localparam int SW = PW + 1;

  logic [SW-1:0] sum;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    pick_o  = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + SW'(k);
      if (sum >= SW'(N_REQ)) begin
        sum = sum - SW'(N_REQ);
      end
      if (req_i[sum[PW-1:0]]) begin
        pick_o              = '0;
        pick_o[sum[PW-1:0]] = 1'b1;
        idx_o               = sum[PW-1:0];
        valid_o             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Round-robin session arbiter sharing one RTC bus driver.
// Optional driver watchdog enabled by RTC_ARB_TIMEOUT_EN.
module rtc_bus_arbiter
  import rtc_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input logic             clk,
  input logic             reset,
  rtc_bus_arbiter_if.slave bus
);

  localparam int PW = $clog2(N_REQ);

  arb_state_e       state_q;
  logic [PW-1:0]    owner_q;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    ptr_d;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] done_q;
  logic [7:0]       rdata_q;
  logic [7:0]       direc_q;
  logic [7:0]       dato_q;
  logic             lea_q;
  logic             flag_q;

  logic [N_REQ-1:0] pick;
  logic [PW-1:0]    pick_idx;
  logic             pick_vld;
  logic             own_req;
  logic             own_stb;

`ifdef RTC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          to_hit;

  assign to_hit = (cnt_q == CW'(TIMEOUT_CYC));
`endif

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  assign own_req = bus.req[owner_q];
  assign own_stb = bus.stb[owner_q];
  assign ptr_d   = (owner_q == PW'(N_REQ - 1)) ? '0
                                               : owner_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      direc_q <= '0;
      dato_q  <= '0;
      lea_q   <= LEA;
      flag_q  <= 1'b0;
`ifdef RTC_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= '0;
`ifdef RTC_ARB_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt_q   <= pick;
            owner_q <= pick_idx;
            state_q <= ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          if (!own_req) begin
            gnt_q   <= '0;
            ptr_q   <= ptr_d;
            state_q <= ST_IDLE;
          end else if (own_stb && !bus.siga) begin
            direc_q <= bus.addr[8*owner_q +: 8];
            dato_q  <= bus.wdata[8*owner_q +: 8];
            lea_q   <= bus.we[owner_q];
            flag_q  <= 1'b1;
            state_q <= ST_START;
`ifdef RTC_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        ST_START: begin
          if (bus.siga) begin
            flag_q  <= 1'b0;
            state_q <= ST_BUSY;
`ifdef RTC_ARB_TIMEOUT_EN
            cnt_q   <= '0;
          end else if (to_hit) begin
            flag_q          <= 1'b0;
            done_q[owner_q] <= 1'b1;
            err_q           <= 1'b1;
            state_q         <= ST_GRANTED;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        ST_BUSY: begin
          if (!bus.siga) begin
            if (lea_q == LEA) begin
              rdata_q <= bus.rtc_rdata;
            end
            done_q[owner_q] <= 1'b1;
            state_q         <= ST_GRANTED;
`ifdef RTC_ARB_TIMEOUT_EN
          end else if (to_hit) begin
            done_q[owner_q] <= 1'b1;
            err_q           <= 1'b1;
            state_q         <= ST_GRANTED;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.done        = done_q;
  assign bus.rdata       = rdata_q;
  assign bus.direc       = direc_q;
  assign bus.dato        = dato_q;
  assign bus.lea_escriba = lea_q;
  assign bus.flag_rtc    = flag_q;
`ifdef RTC_ARB_TIMEOUT_EN
  assign bus.err         = err_q;
`else
  assign bus.err         = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Randomized scoreboard bench for rtc_bus_arbiter with an RTC
// device model behind the driver handshake.
module tb_rtc_bus_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rtc_bus_arbiter_if #(.N_REQ(N)) bus();

  rtc_bus_arbiter #(
    .N_REQ       (N),
    .TIMEOUT_CYC (10)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         g;
    bit         rd;
    bit         er;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rv;
  } exp_t;

  exp_t sbq[$];
  int   gq[$];
  int   checks = 0;
  int   errors = 0;
  bit   drv_mute = 1'b0;
  int   mp = 0;

  logic [7:0] ref_mem [256];
  logic [7:0] dev_mem [256];
  logic [7:0] last_rd = 8'h00;
  logic [7:0] atab [9] = '{8'h21, 8'h22, 8'h23, 8'h24,
                           8'h25, 8'h26, 8'h27, 8'hF0, 8'hF1};
  logic [7:0] dtab [5] = '{8'h24, 8'h25, 8'h26, 8'h27, 8'hF1};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s act=%0h want=%0h", nm, act, want);
    end
  endtask

  function automatic int rr_next(input logic [3:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  // RTC driver/device model: busy window after each flag_rtc.
  initial begin
    logic [7:0] a, d;
    logic       w;
    bit         abort;
    int         n;
    for (int i = 0; i < 256; i++) dev_mem[i] = 8'(i) ^ 8'h5A;
    bus.siga      = 1'b0;
    bus.rtc_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && bus.flag_rtc && !drv_mute) begin
        a = bus.direc;
        d = bus.dato;
        w = bus.lea_escriba;
        abort = 1'b0;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n && !abort; i++) begin
          @(negedge clk);
          if (!rst_n) abort = 1'b1;
        end
        if (!abort) bus.siga = 1'b1;
        n = $urandom_range(1, 6);
        for (int i = 0; i < n && !abort; i++) begin
          @(negedge clk);
          if (!rst_n) abort = 1'b1;
        end
        if (!abort) begin
          if (w) dev_mem[a] = d;
          else bus.rtc_rdata = dev_mem[a];
        end
        bus.siga = 1'b0;
      end
    end
  end

  // Completion monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.done != '0) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected act=%b want=none", bus.done);
        end else begin
          e = sbq.pop_front();
          chk("done_vec", 32'(bus.done), 32'(1) << e.g);
          chk("err", 32'(bus.err), 32'(e.er));
          chk("direc", 32'(bus.direc), 32'(e.a));
          chk("lea", 32'(bus.lea_escriba), 32'(!e.rd));
          if (e.rd) chk("rdata", 32'(bus.rdata), 32'(e.rv));
          else chk("dato", 32'(bus.dato), 32'(e.d));
        end
      end
    end
  end

  // Grant monitor.
  initial begin
    logic [N-1:0] gprev;
    int e;
    gprev = '0;
    forever begin
      @(negedge clk);
      if (bus.gnt != gprev && bus.gnt != '0) begin
        if (gq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant_unexpected act=%b want=none", bus.gnt);
        end else begin
          e = gq.pop_front();
          chk("grant", 32'(bus.gnt), 32'(1) << e);
        end
      end
      gprev = bus.gnt;
    end
  end

  task automatic wait_gnt(input int e);
    int n = 0;
    while (!bus.gnt[e] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("gnt_wait", 32'(bus.gnt[e]), 32'(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.gnt != '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("gnt_release", 32'(bus.gnt), 32'(0));
  endtask

  task automatic do_tx(input int g, input bit rd, input logic [7:0] a,
                       input logic [7:0] d, input bit junk);
    exp_t x;
    int   o;
    int   n;
    x.g  = g;
    x.rd = rd;
    x.er = 1'b0;
    x.a  = a;
    x.d  = d;
    x.rv = rd ? ref_mem[a] : 8'h00;
    if (rd) last_rd = ref_mem[a];
    else ref_mem[a] = d;
    sbq.push_back(x);
    bus.stb[g]            = 1'b1;
    bus.we[g]             = !rd;
    bus.addr[8*g +: 8]    = a;
    bus.wdata[8*g +: 8]   = d;
    if (junk) begin
      o = (g + 1 + $urandom_range(0, 2)) % N;
      bus.stb[o]          = 1'b1;
      bus.we[o]           = 1'($urandom);
      bus.addr[8*o +: 8]  = 8'hF0;
      bus.wdata[8*o +: 8] = 8'hEE;
    end
    @(negedge clk);
    bus.stb = '0;
    // Owner re-strobe while its transaction is in flight.
    if (junk) begin
      bus.stb[g]          = 1'b1;
      bus.we[g]           = rd;
      bus.addr[8*g +: 8]  = ~a;
      bus.wdata[8*g +: 8] = ~d;
      @(negedge clk);
      bus.stb = '0;
    end
    n = 0;
    while (!bus.done[g] && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(bus.done[g]), 32'(1));
  endtask

  task automatic run_session(input logic [3:0] mask, input bit dir);
    logic [3:0] pend;
    int e, nt, nb;
    pend = mask;
    bus.req = pend;
    e = rr_next(pend, mp);
    gq.push_back(e);
    while (pend != '0) begin
      wait_gnt(e);
      if (!dir && $urandom_range(0, 2) == 0) begin
        nb = $urandom_range(0, N - 1);
        if (nb != e) begin
          pend[nb] = 1'b1;
          bus.req  = pend;
        end
      end
      nt = dir ? 5 : $urandom_range(1, 3);
      for (int t = 0; t < nt; t++) begin
        if (dir) do_tx(e, 1'b0, dtab[t], 8'($urandom), 1'b0);
        else do_tx(e, 1'($urandom), atab[$urandom_range(0, 8)],
                   8'($urandom), ($urandom_range(0, 3) == 0));
      end
      pend[e] = 1'b0;
      bus.req = pend;
      mp = (e + 1) % N;
      if (pend != '0) begin
        e = rr_next(pend, mp);
        gq.push_back(e);
      end
      wait_idle();
    end
  endtask

  initial begin
    int  n;
    bit  seen;
    bus.req   = '0;
    bus.stb   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_flag", 32'(bus.flag_rtc), 32'(0));
    chk("rst_direc", 32'(bus.direc), 32'(0));
    chk("rst_dato", 32'(bus.dato), 32'(0));
    chk("rst_lea", 32'(bus.lea_escriba), 32'(0));
    chk("rst_rdata", 32'(bus.rdata), 32'(0));
    chk("rst_err", 32'(bus.err), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_session(4'b1011, 1'b1);

    bus.req = 4'b0001;
    gq.push_back(rr_next(4'b0001, mp));
    wait_gnt(0);
    bus.stb[2]          = 1'b1;
    bus.we[2]           = 1'b1;
    bus.addr[8*2 +: 8]  = 8'h22;
    bus.wdata[8*2 +: 8] = 8'h33;
    @(negedge clk);
    bus.stb = '0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.flag_rtc || bus.done != '0) seen = 1'b1;
    end
    chk("nonowner_quiet", 32'(seen), 32'(0));
    bus.req = '0;
    mp = 1;
    wait_idle();

    bus.req = 4'b0001;
    gq.push_back(rr_next(4'b0001, mp));
    wait_gnt(0);
    bus.stb[0]         = 1'b1;
    bus.we[0]          = 1'b0;
    bus.addr[0 +: 8]   = 8'h21;
    @(negedge clk);
    bus.stb = '0;
    n = 0;
    while (!bus.siga && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("siga_rise", 32'(bus.siga), 32'(1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_flag", 32'(bus.flag_rtc), 32'(0));
    chk("midrst_gnt", 32'(bus.gnt), 32'(0));
    chk("midrst_done", 32'(bus.done), 32'(0));
    bus.req = '0;
    mp = 0;
    last_rd = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_session(4'b0110, 1'b0);

    repeat (14) run_session(4'($urandom_range(1, 15)), 1'b0);

`ifdef RTC_ARB_TIMEOUT_EN
    begin
      exp_t x;
      drv_mute = 1'b1;
      bus.req = 4'b0100;
      gq.push_back(rr_next(4'b0100, mp));
      wait_gnt(2);
      x.g  = 2;
      x.rd = 1'b1;
      x.er = 1'b1;
      x.a  = 8'h21;
      x.d  = 8'h00;
      x.rv = last_rd;
      sbq.push_back(x);
      bus.stb[2]         = 1'b1;
      bus.we[2]          = 1'b0;
      bus.addr[8*2 +: 8] = 8'h21;
      n = 0;
      do begin
        @(negedge clk);
        bus.stb = '0;
        n++;
      end while (!bus.done[2] && n < 40);
      chk("timeout_lat", 32'(n), 32'(12));
      chk("timeout_flag", 32'(bus.flag_rtc), 32'(0));
      bus.req = '0;
      mp = 3;
      wait_idle();
      drv_mute = 1'b0;
    end
`endif

    repeat (10) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'(0));
    chk("gq_empty", 32'(gq.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
